mmio_led_pwm: RTL

Memory-mapped LED/RGB peripheral that responds to data-memory bus writes and reads at a single word address and turns four 8-bit duty-cycle fields into PWM drive for the user LED and the RGB LED. It sits on the dmem port beside data RAM: the core (or a test sequencer) stores a colour word, and this block decodes the access, updates its register and generates glitch-free PWM outputs. Outputs are active-high; board-level inversion happens at the top level.

---
 rtl/mmio_led_pwm.sv | 105 ++++++++++
 1 files changed

// File: rtl/mmio_led_pwm.sv
// Single-word memory-mapped LED/RGB colour register with four 8-bit PWM channels.
// Loads return one cycle after the address; PWM duty changes take effect only at period boundaries.
module mmio_led_pwm #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFFFC,
  parameter int          PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  funct3,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  output logic [31:0] dmem_data_out,
  output logic        hit,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic          w_match;
  logic [1:0]    w_off;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ctrl_nxt;
  logic [31:0]   w_rdata;
  logic          w_tick;
  logic          w_boundary;

  logic [31:0]   r_ctrl;
  logic [31:0]   r_shd;
  logic [PW-1:0] r_pre;
  logic [7:0]    r_cnt;

  assign w_match    = (dmem_address[31:2] == BASE_ADDR[31:2]);
  assign w_off      = dmem_address[1:0];
  assign w_byte     = r_ctrl[{w_off, 3'b000} +: 8];
  assign w_half     = r_ctrl[{w_off[1], 4'b0000} +: 16];
  assign w_tick     = (r_pre == PRE_LAST);
  assign w_boundary = w_tick && (r_cnt == 8'hFF);

  // Misaligned halfword/word stores are silently dropped.
  always_comb begin
    w_ctrl_nxt = r_ctrl;
    if (w_match && dmem_wren) begin
      case (funct3)
        3'b000: w_ctrl_nxt[{w_off, 3'b000} +: 8] = dmem_data_in[7:0];
        3'b001: if (!w_off[0]) w_ctrl_nxt[{w_off[1], 4'b0000} +: 16] = dmem_data_in[15:0];
        3'b010: if (w_off == 2'd0) w_ctrl_nxt = dmem_data_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    if (w_match && !dmem_wren) begin
      case (funct3)
        3'b000: w_rdata = {{24{w_byte[7]}}, w_byte};
        3'b100: w_rdata = {24'd0, w_byte};
        3'b001: if (!w_off[0]) w_rdata = {{16{w_half[15]}}, w_half};
        3'b101: if (!w_off[0]) w_rdata = {16'd0, w_half};
        3'b010: if (w_off == 2'd0) w_rdata = r_ctrl;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl        <= 32'd0;
      dmem_data_out <= 32'd0;
      hit           <= 1'b0;
    end else begin
      r_ctrl        <= w_ctrl_nxt;
      dmem_data_out <= w_rdata;
      hit           <= w_match;
    end
  end

  // Shadow captures the pre-write ctrl on the boundary edge, so a write there lands one period later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
      r_cnt <= 8'd0;
      r_shd <= 32'd0;
      led   <= 1'b0;
      red   <= 1'b0;
      green <= 1'b0;
      blue  <= 1'b0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (w_tick)     r_cnt <= r_cnt + 8'd1;
      if (w_boundary) r_shd <= r_ctrl;
      led   <= (r_cnt < r_shd[31:24]);
      red   <= (r_cnt < r_shd[23:16]);
      green <= (r_cnt < r_shd[15:8]);
      blue  <= (r_cnt < r_shd[7:0]);
    end
  end

endmodule
